// File: rtl/sudoku_if.sv
// ---------------------------------------------------------------------------
// sudoku_if
// Groups the Tiny Tapeout user-project pins of the sudoku checker into one bundle.
//   ena      : design selected. When it is 0, the design holds all of its state.
//   ui_in    : [3:0] write value, [6] start check, [7] write strobe
//   uio_in   : [6:0] cell address (row*9+col)
//   uo_out   : [3:0] readback, [4] busy, [5] done, [6] valid, [7] complete
//   uio_out  : always 8'h00
//   uio_oe   : always 8'h00 (every uio pin is an input)
// Modports:
//   master   : the host or testbench side, which drives the inputs.
//   slave    : the sudoku core side, which drives the outputs.
// ---------------------------------------------------------------------------
interface sudoku_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/sudoku.sv
// ---------------------------------------------------------------------------
// sudoku
// Holds a 9x9 Sudoku grid (81 cells, 4 bits each). The host writes and reads
// cells through the TT pins. On a start request, the design checks the grid
// against the rules one cell per enabled cycle. It covers the 9 rows, the
// 9 columns and the 9 3x3 boxes, which is 243 cells in total.
//
// Ports:
//   clk    : single clock. All state updates on the rising edge.
//   rst_n  : asynchronous reset, ACTIVE-HIGH. The name follows the TT pinout.
//   pins   : sudoku_if.slave, which carries ena, ui_in, uio_in, uo_out,
//            uio_out and uio_oe.
//
// Configuration:
//   SUDOKU_EARLY_EXIT_EN : when defined, the scan stops at the first cell that
//   repeats a digit within its group. That cell's index + 1 is the latency.
//   When undefined, the scan always runs all 243 cells. In both builds the
//   reported result is the same.
// ---------------------------------------------------------------------------
module sudoku (
    input  logic     clk,
    input  logic     rst_n,
    sudoku_if.slave  pins
);
    typedef enum logic {ST_IDLE, ST_SCAN} state_t;

    state_t     state_q;
    logic [3:0] cellMem_q [0:80];
    logic [4:0] group_q;
    logic [3:0] elem_q;
    logic [8:0] seen_q;
    logic       conflict_q;
    logic       empty_q;
    logic       done_q;
    logic       valid_q;
    logic       complete_q;

    logic [6:0] addr;
    logic       addrOk;
    logic       writeReq;
    logic       startReq;
    logic [3:0] writeVal;
    logic [3:0] rdVal;

    assign addr     = pins.uio_in[6:0];
    assign addrOk   = (addr <= 7'd80);
    assign writeReq = pins.ui_in[7] & (state_q == ST_IDLE) & addrOk;
    // A raised write strobe blocks start, even when the write targets an
    // out-of-range address and is then dropped.
    assign startReq = pins.ui_in[6] & ~pins.ui_in[7] & (state_q == ST_IDLE);
    assign writeVal = (pins.ui_in[3:0] <= 4'd9) ? pins.ui_in[3:0] : 4'd0;
    assign rdVal    = addrOk ? cellMem_q[addr] : 4'd0;

    assign pins.uo_out  = {complete_q, valid_q, done_q, (state_q == ST_SCAN), rdVal};
    assign pins.uio_out = 8'h00;
    assign pins.uio_oe  = 8'h00;

    logic unusedPins;
    assign unusedPins = &{1'b0, pins.ui_in[5:4], pins.uio_in[7]};

    // Map (group, elem) to a cell address.
    // Groups 0..8 are rows, 9..17 are columns, 18..26 are boxes.
    logic [6:0] grp7;
    logic [6:0] elm7;
    logic [6:0] boxN;
    logic [6:0] scanIdx;
    always_comb begin
        grp7    = {2'b00, group_q};
        elm7    = {3'b000, elem_q};
        boxN    = 7'd0;
        scanIdx = 7'd0;
        if (group_q < 5'd9) begin
            scanIdx = grp7 * 7'd9 + elm7;
        end else if (group_q < 5'd18) begin
            scanIdx = elm7 * 7'd9 + (grp7 - 7'd9);
        end else begin
            boxN    = grp7 - 7'd18;
            scanIdx = (7'd3 * (boxN / 7'd3) + elm7 / 7'd3) * 7'd9
                    + 7'd3 * (boxN % 7'd3) + elm7 % 7'd3;
        end
    end

    // Update the per-group seen mask for the cell under the scan pointer.
    // A digit already in the mask is a conflict. A zero only marks the grid
    // as not complete.
    logic [3:0] scanVal;
    logic [8:0] valOneHot;
    logic       hit;
    logic [8:0] seen_d;
    logic       conflict_d;
    logic       empty_d;
    logic       lastCell;
    always_comb begin
        scanVal    = cellMem_q[scanIdx];
        valOneHot  = (scanVal == 4'd0) ? 9'd0 : (9'd1 << (scanVal - 4'd1));
        hit        = |(valOneHot & seen_q);
        seen_d     = seen_q | valOneHot;
        conflict_d = conflict_q | hit;
        empty_d    = empty_q | (scanVal == 4'd0);
        lastCell   = (group_q == 5'd26) && (elem_q == 4'd8);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= ST_IDLE;
            for (int i = 0; i < 81; i++) cellMem_q[i] <= 4'd0;
            group_q    <= 5'd0;
            elem_q     <= 4'd0;
            seen_q     <= 9'd0;
            conflict_q <= 1'b0;
            empty_q    <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            complete_q <= 1'b0;
        end else if (pins.ena) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (writeReq) begin
                        cellMem_q[addr] <= writeVal;
                        done_q          <= 1'b0;
                        valid_q         <= 1'b0;
                        complete_q      <= 1'b0;
                    end else if (startReq) begin
                        state_q    <= ST_SCAN;
                        group_q    <= 5'd0;
                        elem_q     <= 4'd0;
                        seen_q     <= 9'd0;
                        conflict_q <= 1'b0;
                        empty_q    <= 1'b0;
                        done_q     <= 1'b0;
                        valid_q    <= 1'b0;
                        complete_q <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    seen_q     <= seen_d;
                    conflict_q <= conflict_d;
                    empty_q    <= empty_d;
`ifdef SUDOKU_EARLY_EXIT_EN
                    if (hit) begin
                        state_q    <= ST_IDLE;
                        done_q     <= 1'b1;
                        valid_q    <= 1'b0;
                        complete_q <= 1'b0;
                    end else
`endif
                    if (lastCell) begin
                        state_q    <= ST_IDLE;
                        done_q     <= 1'b1;
                        valid_q    <= ~conflict_d;
                        complete_q <= ~conflict_d & ~empty_d;
                    end else if (elem_q == 4'd8) begin
                        elem_q  <= 4'd0;
                        group_q <= group_q + 5'd1;
                        seen_q  <= 9'd0;
                    end else begin
                        elem_q <= elem_q + 4'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sudoku.sv
// ---------------------------------------------------------------------------
// tb_sudoku
// Self-checking bench for the sudoku checker.
// A behavioural model tracks the grid contents and the scan status, and a
// compare process checks every uo_out/uio_out/uio_oe value against it.
// Directed cases use literal expectations. Randomized grids and randomized
// mid-scan traffic then exercise the model.
// ---------------------------------------------------------------------------
module tb_sudoku;
    logic clk = 1'b0;
    logic rst_n;

    sudoku_if pins();

    sudoku dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pins  (pins)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [3:0] mCell [81];
    logic       mBusy, mDone, mValid, mComplete;
    int         mSteps;
    logic [9:0] mRes;   // {valid, complete, latency[7:0]}

    logic [3:0] gridBuf [81];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Apply the Sudoku rules straight to the grid. Each group is a set of
    // nine cells. The result records whether any digit repeats within a
    // group, and where in the scan order the first repeat appears.
    function automatic logic [9:0] calcResult();
        int   cnt [10];
        logic conflict;
        logic empty;
        int   pos;
        int   firstPos;
        int   a;
        int   v;
        int   lat;
        conflict = 1'b0;
        empty    = 1'b0;
        pos      = 0;
        firstPos = -1;
        for (int i = 0; i < 81; i++) if (mCell[i] == 4'd0) empty = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int g = 0; g < 9; g++) begin
                for (int d = 0; d < 10; d++) cnt[d] = 0;
                for (int e = 0; e < 9; e++) begin
                    if (k == 0)      a = g * 9 + e;
                    else if (k == 1) a = e * 9 + g;
                    else             a = ((g / 3) * 3 + e / 3) * 9 + (g % 3) * 3 + e % 3;
                    v = int'(mCell[a]);
                    if (v != 0) begin
                        cnt[v]++;
                        if (cnt[v] > 1) begin
                            conflict = 1'b1;
                            if (firstPos < 0) firstPos = pos;
                        end
                    end
                    pos++;
                end
            end
        end
        lat = 243;
`ifdef SUDOKU_EARLY_EXIT_EN
        if (firstPos >= 0) lat = firstPos + 1;
`endif
        return {~conflict, ~conflict & ~empty, 8'(lat)};
    endfunction

    // Model update on each rising edge. Async reset matches the DUT.
    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < 81; i++) mCell[i] <= 4'd0;
            mBusy     <= 1'b0;
            mDone     <= 1'b0;
            mValid    <= 1'b0;
            mComplete <= 1'b0;
            mSteps    <= 0;
            mRes      <= 10'd0;
        end else if (pins.ena) begin
            if (mBusy) begin
                if (mSteps + 1 == int'(mRes[7:0])) begin
                    mBusy     <= 1'b0;
                    mDone     <= 1'b1;
                    mValid    <= mRes[9];
                    mComplete <= mRes[8];
                end else begin
                    mSteps <= mSteps + 1;
                end
            end else if (pins.ui_in[7]) begin
                if (pins.uio_in[6:0] <= 7'd80) begin
                    mCell[pins.uio_in[6:0]] <= (pins.ui_in[3:0] > 4'd9) ? 4'd0 : pins.ui_in[3:0];
                    mDone     <= 1'b0;
                    mValid    <= 1'b0;
                    mComplete <= 1'b0;
                end
            end else if (pins.ui_in[6]) begin
                mBusy     <= 1'b1;
                mSteps    <= 0;
                mRes      <= calcResult();
                mDone     <= 1'b0;
                mValid    <= 1'b0;
                mComplete <= 1'b0;
            end
        end
    end

    function automatic logic [7:0] expUo();
        logic [3:0] rd;
        rd = (pins.uio_in[6:0] <= 7'd80) ? mCell[pins.uio_in[6:0]] : 4'd0;
        return {mComplete, mValid, mDone, mBusy, rd};
    endfunction

    // Compare process, sampling on the falling edge
    always @(negedge clk) begin
        checkOutput("uo_out_model", {24'd0, pins.uo_out}, {24'd0, expUo()});
        checkOutput("uio_out", {24'd0, pins.uio_out}, 32'h0);
        checkOutput("uio_oe", {24'd0, pins.uio_oe}, 32'h0);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic e, input logic [7:0] ui, input logic [7:0] uio);
        pins.ena    = e;
        pins.ui_in  = ui;
        pins.uio_in = uio;
    endtask

    task automatic writeCell(input int a, input int v);
        logic [7:0] av;
        logic [3:0] vv;
        av = 8'(a);
        vv = 4'(v);
        tick();
        applyStimulus(1'b1, {4'b1000, vv}, av);
        tick();
        applyStimulus(1'b1, 8'h00, av);
    endtask

    task automatic readFull(input string nm, input int a, input logic [7:0] exp);
        tick();
        applyStimulus(1'b1, 8'h00, 8'(a));
        @(negedge clk);
        checkOutput(nm, {24'd0, pins.uo_out}, {24'd0, exp});
    endtask

    task automatic loadGrid();
        for (int a = 0; a < 81; a++) begin
            tick();
            applyStimulus(1'b1, {4'b1000, gridBuf[a]}, 8'(a));
        end
        tick();
        applyStimulus(1'b1, 8'h00, 8'h00);
    endtask

    task automatic startScan();
        tick();
        applyStimulus(1'b1, 8'h40, 8'h00);
        tick();
        applyStimulus(1'b1, 8'h00, 8'h00);
    endtask

    task automatic waitIdle(output int cnt);
        cnt = 0;
        @(negedge clk);
        while (pins.uo_out[4] && cnt < 3000) begin
            cnt++;
            @(negedge clk);
        end
        checkOutput("scan_timeout", {31'd0, pins.uo_out[4]}, 32'd0);
    endtask

    task automatic fillSolved();
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                gridBuf[r * 9 + c] = 4'(((r * 3 + r / 3 + c) % 9) + 1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt;
        int p [9];
        int j;
        int tmp;
        int nMods;
        int expLat;

        rst_n = 1'b1;
        applyStimulus(1'b1, 8'h00, 8'h00);
        repeat (3) tick();
        rst_n = 1'b0;

        // Reset state
        readFull("rst_a0", 0, 8'h00);
        readFull("rst_a40", 40, 8'h00);
        readFull("rst_a80", 80, 8'h00);
        checkOutput("rst_uio_oe", {24'd0, pins.uio_oe}, 32'h0);

        // Basic write/readback
        writeCell(40, 5);
        readFull("wr40", 40, 8'h05);
        writeCell(3, 12);
        readFull("wr3_clamp", 3, 8'h00);
        writeCell(100, 9);
        readFull("rd100", 100, 8'h00);
        for (int a = 0; a < 81; a++)
            readFull("sweep_after_wr", a, (a == 40) ? 8'h05 : 8'h00);

        // Solved grid
        fillSolved();
        loadGrid();
        readFull("solved_a10", 10, 8'h05);
        startScan();
        waitIdle(cnt);
        checkOutput("solved_lat", cnt, 32'd243);
        checkOutput("solved_flags", {28'd0, pins.uo_out[7:4]}, 32'hE);

        // Solved grid with one hole
        writeCell(80, 0);
        startScan();
        waitIdle(cnt);
        checkOutput("hole_lat", cnt, 32'd243);
        checkOutput("hole_flags", {28'd0, pins.uo_out[7:4]}, 32'h6);

        // Row conflict in an otherwise empty grid
        for (int a = 0; a < 81; a++) gridBuf[a] = 4'd0;
        gridBuf[0] = 4'd7;
        gridBuf[8] = 4'd7;
        loadGrid();
        startScan();
        waitIdle(cnt);
`ifdef SUDOKU_EARLY_EXIT_EN
        expLat = 9;
`else
        expLat = 243;
`endif
        checkOutput("conflict_lat", cnt, expLat);
        checkOutput("conflict_flags", {28'd0, pins.uo_out[7:4]}, 32'h2);

        // Start and write while busy are ignored. Reset then aborts the scan.
        fillSolved();
        loadGrid();
        startScan();
        repeat (5) tick();
        applyStimulus(1'b1, 8'hC9, 8'h00);
        tick();
        applyStimulus(1'b1, 8'h00, 8'h00);
        @(negedge clk);
        checkOutput("midscan_busy", {31'd0, pins.uo_out[4]}, 32'd1);
        checkOutput("midscan_cell0", {28'd0, pins.uo_out[3:0]}, 32'd1);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", {31'd0, pins.uo_out[4]}, 32'd0);
        for (int a = 0; a < 81; a++) readFull("abort_sweep", a, 8'h00);
        tick();
        rst_n = 1'b0;

        // Randomized grids with random traffic during the scan
        for (int run = 0; run < 12; run++) begin
            for (int i = 0; i < 9; i++) p[i] = i + 1;
            for (int i = 8; i > 0; i--) begin
                j    = int'($urandom_range(0, i));
                tmp  = p[i];
                p[i] = p[j];
                p[j] = tmp;
            end
            for (int r = 0; r < 9; r++)
                for (int c = 0; c < 9; c++)
                    gridBuf[r * 9 + c] = 4'(p[(r * 3 + r / 3 + c) % 9]);
            nMods = int'($urandom_range(0, 3));
            for (int m = 0; m < nMods; m++)
                gridBuf[$urandom_range(0, 80)] = 4'($urandom_range(0, 15));
            loadGrid();
            startScan();
            cnt = 0;
            @(negedge clk);
            while (pins.uo_out[4] && cnt < 3000) begin
                tick();
                applyStimulus(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom));
                cnt++;
                @(negedge clk);
            end
            pins.ui_in = 8'h00;
            pins.ena   = 1'b1;
            checkOutput("rand_scan_end", {31'd0, pins.uo_out[4]}, 32'd0);
            repeat (3) tick();
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
